boot_byte_loader: RTL and testbench
===================================

Name: boot_byte_loader

Overview:
- Consumes the byte stream from the boot UART receiver (`byte_valid`/`byte_data`).
- Parses a framed load command and writes 32-bit little-endian words into instruction/data memory through a simple write handshake.
- Holds the CPU in reset via `busy` while a load is in progress.
- Reports completion, checksum errors, byte overrun and inter-byte timeout.

Parameters:
- `clk_frequency`, 50000000, clock frequency in Hz.
- `baud_rate`, 57600, UART baud rate; used only for the timeout.
- `timeout_symbols`, 16, idle gap in UART symbol times that aborts a frame. Timeout cycles = (`clk_frequency` / `baud_rate`) * `timeout_symbols`.
- `sync_byte`, 8'hA5, frame start marker.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `byte_valid`  in  1  one-cycle strobe, received byte available
- `byte_data`  in  8  received byte, valid with `byte_valid`
- `mem_we`  out  1  write request, held until accepted
- `mem_addr`  out  32  byte address of word write
- `mem_wdata`  out  32  word to write
- `mem_ready`  in  1  memory accepts write this cycle when `mem_we`=1
- `busy`  out  1  frame in progress (`state`!=IDLE); drives CPU reset hold
- `load_done`  out  1  one-cycle pulse, frame completed with good checksum
- `load_error`  out  1  sticky; set on checksum mismatch, timeout or overrun; cleared when the next sync byte is accepted
- `overrun`  out  1  sticky; byte arrived while a write was pending; cleared with `load_error`

Behaviour:
- Reset (async, `reset_n`=0): `state`=IDLE; `mem_we`=0; `mem_addr`=0; `mem_wdata`=0; `busy`=0; `load_done`=0; `load_error`=0; `overrun`=0; checksum, counters and timeout counter all 0. Reset mid-frame abandons the frame; no partial write is issued after release.
- Frame format: sync, ADDR[4 bytes LE], LEN[2 bytes LE, word count], DATA[LEN*4 bytes, each word LE], CSUM[1 byte].
- Checksum rule: the 8-bit sum of all bytes after sync, including CSUM, must equal 0 mod 256.
- States:
  - IDLE: a byte equal to `sync_byte` -> ADDR; clears checksum, `load_error`, `overrun`. Any other byte is ignored.
  - ADDR: collect 4 bytes LE into the address register -> LEN.
  - LEN: collect 2 bytes LE into the word counter. If LEN=0 -> CSUM; otherwise -> DATA.
  - DATA: collect 4 bytes LE into the word register; on the 4th byte -> WRITE.
  - WRITE: `mem_we`=1 with `mem_addr`=current address and `mem_wdata`=word, held stable until `mem_ready`=1.
    - On accept: address += 4 (wraps mod 2^32), word counter -= 1, `mem_we` drops next cycle.
    - Counter now 0 -> CSUM; otherwise -> DATA.
  - CSUM: one byte is added to the checksum.
    - Sum == 0: `load_done` pulses 1 cycle -> IDLE.
    - Sum != 0: `load_error` set -> IDLE.
- Every accepted byte (outside IDLE) is added to the 8-bit running checksum in the cycle it arrives.
- Latency: `mem_we` rises the cycle after the 4th data byte's `byte_valid`. `load_done` rises the cycle after the CSUM byte's `byte_valid`.
- Overrun: `byte_valid` while in WRITE sets `overrun` and `load_error`. The byte is dropped, and the pending write still completes.
- Timeout: the counter resets on each `byte_valid` and counts while not in IDLE and not in WRITE. Reaching the timeout count -> IDLE, `load_error`=1. No write is issued for a partial word.
- Memory writes are committed before checksum verification. A bad frame leaves earlier words written; software must retry the whole frame.
- Back-to-back frames: a sync byte may arrive the cycle after the CSUM byte. It is processed normally in IDLE.
- `byte_data` is sampled only when `byte_valid`=1.

Test Plan:
- Good frame: A5 00 01 00 00 01 00 78 56 34 12 EA -> one write with `mem_addr`=32'h00000100, `mem_wdata`=32'h12345678; `load_done` pulse; `load_error`=0; `busy` low afterwards.
- Two-word frame to 32'hFFFFFFFC with `mem_ready` held low 5 cycles per write -> `mem_we` and `mem_wdata` stable through the stall; second write at 32'h00000000 (wrap); `load_done` pulse.
- Same frame as the good frame with CSUM=EB -> write still issued, `load_error`=1, no `load_done`; next A5 byte clears `load_error`.
- Stop after 6 data bytes, idle beyond 16 symbol times -> `state` IDLE, `load_error`=1, `mem_we` never asserted for the partial word, `busy`=0.
- Byte injected during a stalled WRITE -> `overrun`=1, `load_error`=1, pending write completes with the original data.
- LEN=0 frame A5 00 00 00 00 00 00 00 -> no writes, `load_done` pulse; `reset_n` pulsed mid-DATA -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/boot_byte_loader.sv
// boot_byte_loader: parses framed UART load commands and writes little-endian words to memory
module boot_byte_loader #(
  parameter int clk_frequency = 50000000,
  parameter int baud_rate = 57600,
  parameter int timeout_symbols = 16,
  parameter logic [7:0] sync_byte = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        load_done,
  output logic        load_error,
  output logic        overrun
);
  localparam int timeout_cycles = (clk_frequency / baud_rate) * timeout_symbols;
  localparam int tw = $clog2(timeout_cycles + 1);
  localparam logic [tw-1:0] tmax = tw'(timeout_cycles - 1);
  localparam logic [2:0] s_idle = 3'd0, s_addr = 3'd1, s_len = 3'd2, s_data = 3'd3,
                         s_write = 3'd4, s_csum = 3'd5;
  logic [2:0]    state;
  logic [31:0]   addr, word;
  logic [15:0]   cnt;
  logic [1:0]    bcnt;
  logic [7:0]    csum;
  logic [tw-1:0] tcnt;
  assign mem_addr = addr;
  assign mem_wdata = word;
  assign busy = state != s_idle;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= s_idle;
      addr <= '0;
      word <= '0;
      cnt <= '0;
      bcnt <= '0;
      csum <= '0;
      tcnt <= '0;
      mem_we <= 1'b0;
      load_done <= 1'b0;
      load_error <= 1'b0;
      overrun <= 1'b0;
    end else begin
      load_done <= 1'b0;
      tcnt <= (byte_valid || state == s_idle || state == s_write) ? '0 : tcnt + 1'b1;
      if (state == s_write) begin
        // a byte landing while the write is pending is dropped, not checksummed
        if (byte_valid) begin
          overrun <= 1'b1;
          load_error <= 1'b1;
        end
        if (mem_ready) begin
          mem_we <= 1'b0;
          addr <= addr + 32'd4;
          cnt <= cnt - 16'd1;
          state <= (cnt == 16'd1) ? s_csum : s_data;
        end
      end else if (byte_valid) begin
        csum <= csum + byte_data;
        bcnt <= bcnt + 2'd1;
        case (state)
          s_idle: begin
            if (byte_data == sync_byte) begin
              state <= s_addr;
              load_error <= 1'b0;
              overrun <= 1'b0;
            end
            csum <= '0;
            bcnt <= '0;
          end
          s_addr: begin
            addr <= {byte_data, addr[31:8]};
            if (bcnt == 2'd3) state <= s_len;
          end
          s_len: begin
            cnt <= {byte_data, cnt[15:8]};
            if (bcnt[0]) begin
              bcnt <= '0;
              state <= ({byte_data, cnt[15:8]} == 16'd0) ? s_csum : s_data;
            end
          end
          s_data: begin
            word <= {byte_data, word[31:8]};
            if (bcnt == 2'd3) begin
              state <= s_write;
              mem_we <= 1'b1;
            end
          end
          s_csum: begin
            state <= s_idle;
            if (csum + byte_data == 8'd0) load_done <= 1'b1;
            else load_error <= 1'b1;
          end
          default: state <= s_idle;
        endcase
      end else if (state != s_idle && tcnt == tmax) begin
        state <= s_idle;
        load_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_boot_byte_loader.sv
// tb_boot_byte_loader: scoreboard bench for boot_byte_loader
module tb_boot_byte_loader;
  logic clk = 1'b0, reset_n = 1'b0, byte_valid = 1'b0, mem_ready = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic mem_we, busy, load_done, load_error, overrun;
  logic [31:0] mem_addr, mem_wdata;
  int errors = 0, checks = 0, stall = 0, dones = 0, d0;
  logic [63:0] exp_q[$];
  logic [63:0] held;
  logic [7:0] run_sum;

  always #5 clk = ~clk;

  boot_byte_loader dut (
    .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .load_done(load_done), .load_error(load_error), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // memory model: stalls each write by 'stall' cycles and scores accepted writes
  initial begin
    int sc;
    sc = 0;
    forever begin
      @(negedge clk);
      if (load_done) dones++;
      if (!reset_n) begin
        mem_ready = 1'b0;
        sc = 0;
      end else if (mem_we) begin
        if (sc == 0) held = {mem_addr, mem_wdata};
        else check("write_stable", {mem_addr, mem_wdata}, held);
        if (sc >= stall) begin
          mem_ready = 1'b1;
          if (exp_q.size() == 0) check("unexpected_write", 1, 0);
          else check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
        sc++;
      end else begin
        mem_ready = 1'b0;
        sc = 0;
      end
    end
  end

  task automatic wait_we_low();
    int n;
    n = 0;
    while (mem_we && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("we_release", mem_we, 0);
  endtask

  task automatic send(input logic [7:0] b);
    wait_we_low();
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data = b;
    run_sum = run_sum + b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] a, input logic [15:0] n, input logic [31:0] w0,
                       input logic [31:0] w1, input logic bad);
    logic [31:0] w;
    send(8'hA5);
    run_sum = 8'h00;
    for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
    send(n[7:0]);
    send(n[15:8]);
    for (int k = 0; k < int'(n); k++) begin
      w = (k == 0) ? w0 : w1;
      exp_q.push_back({a + 32'(4 * k), w});
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    end
    send(8'(8'h00 - run_sum) + {7'd0, bad});
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] g [12];
    g = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEA};
    run_sum = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {mem_we, busy, load_done, load_error, overrun}, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    reset_n = 1'b1;

    // good single-word frame with latency checks
    d0 = dones;
    exp_q.push_back({32'h00000100, 32'h12345678});
    for (int i = 0; i < 12; i++) begin
      send(g[i]);
      if (i == 3) check("busy_mid", busy, 1);
      if (i == 10) check("we_latency", mem_we, 1);
      if (i == 11) check("done_latency", load_done, 1);
    end
    @(posedge clk); #1;
    check("done_pulse_width", load_done, 0);
    check("good_error", load_error, 0);
    check("good_busy", busy, 0);
    check("good_dones", dones - d0, 1);
    check("good_queue", exp_q.size(), 0);

    // two words across the address wrap with stalled memory
    d0 = dones;
    stall = 5;
    frame(32'hFFFFFFFC, 16'd2, 32'hAABBCCDD, 32'h11223344, 1'b0);
    stall = 0;
    check("wrap_dones", dones - d0, 1);
    check("wrap_queue", exp_q.size(), 0);
    check("wrap_error", load_error, 0);

    // bad checksum: write still lands, error instead of done
    d0 = dones;
    frame(32'h00000100, 16'd1, 32'h12345678, 32'h0, 1'b1);
    check("bad_dones", dones - d0, 0);
    check("bad_error", load_error, 1);
    check("bad_queue", exp_q.size(), 0);
    send(8'hA5);
    run_sum = 8'h00;
    check("sync_clears_error", load_error, 0);

    // timeout after a partial second word
    send(8'h00); send(8'h02); send(8'h00); send(8'h00);
    send(8'h02); send(8'h00);
    exp_q.push_back({32'h00000200, 32'h01020304});
    send(8'h04); send(8'h03); send(8'h02); send(8'h01);
    send(8'h55); send(8'h66);
    repeat (100) @(posedge clk);
    #1;
    check("busy_before_timeout", busy, 1);
    check("error_before_timeout", load_error, 0);
    repeat (14000) @(posedge clk);
    #1;
    check("timeout_busy", busy, 0);
    check("timeout_error", load_error, 1);
    check("timeout_we", mem_we, 0);
    check("timeout_queue", exp_q.size(), 0);

    // overrun during a stalled write
    d0 = dones;
    stall = 20;
    send(8'hA5);
    run_sum = 8'h00;
    check("overrun_cleared", {load_error, overrun}, 0);
    send(8'h00); send(8'h03); send(8'h00); send(8'h00);
    send(8'h01); send(8'h00);
    exp_q.push_back({32'h00000300, 32'hCAFEF00D});
    send(8'h0D); send(8'hF0); send(8'hFE); send(8'hCA);
    repeat (3) @(posedge clk);
    #1;
    check("overrun_pending", mem_we, 1);
    byte_valid = 1'b1;
    byte_data = 8'h77;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    check("overrun_flag", overrun, 1);
    check("overrun_error", load_error, 1);
    send(8'(8'h00 - run_sum));
    repeat (2) @(posedge clk);
    #1;
    stall = 0;
    check("overrun_queue", exp_q.size(), 0);
    check("overrun_dones", dones - d0, 1);
    check("overrun_sticky", {overrun, load_error}, 2'b11);

    // zero-length frame
    d0 = dones;
    frame(32'h00000000, 16'd0, 32'h0, 32'h0, 1'b0);
    check("len0_dones", dones - d0, 1);
    check("len0_error", load_error, 0);

    // reset mid-DATA
    send(8'hA5);
    send(8'h00); send(8'h04); send(8'h00); send(8'h00);
    send(8'h01); send(8'h00);
    send(8'h99); send(8'h88);
    #2 reset_n = 1'b0;
    #1;
    check("rst_flags", {mem_we, busy, load_done, load_error, overrun}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    #3 reset_n = 1'b1;
    run_sum = 8'h00;
    send(8'h11); send(8'h22);
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle", {mem_we, busy}, 0);
    d0 = dones;
    frame(32'h00000500, 16'd1, 32'hDEADBEEF, 32'h0, 1'b0);
    check("post_rst_dones", dones - d0, 1);
    check("post_rst_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
